// File: rtl/tank_hit_tracker.sv
// Turns per-frame bullet collision codes into tank health, hit/kill pulses and the round state.
// Optional build macro HIT_SIDE_LOG_EN adds last_side1/last_side2 (side of the latest counted hit).
module tank_hit_tracker #(
  parameter int unsigned HEALTH_MAX       = 3,
  parameter int unsigned COOLDOWN_FRAMES  = 30,
  parameter int unsigned OVER_HOLD_FRAMES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] tank_bullet,
  input  logic [2:0] tank_bullet2,
  input  logic [2:0] disappear,
  input  logic [2:0] disappear2,
  input  logic       restart,
  output logic [2:0] health1,
  output logic [2:0] health2,
  output logic       tank1_hit,
  output logic       tank2_hit,
  output logic       bullet_kill,
  output logic       bullet2_kill,
  output logic [1:0] game_state,
  output logic       freeze
`ifdef HIT_SIDE_LOG_EN
  ,
  output logic [1:0] last_side1,
  output logic [1:0] last_side2
`endif
);

  localparam int unsigned HP_W  = 3;
  localparam int unsigned CNT_W = 8;
  localparam logic [HP_W-1:0]  HEALTH_INIT = HP_W'(HEALTH_MAX);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(OVER_HOLD_FRAMES);
  localparam logic [2:0]       IDLE_CODE   = 3'b100;

  typedef enum logic [1:0] {
    PLAY   = 2'b00,
    P1_WIN = 2'b01,
    P2_WIN = 2'b10,
    DRAW   = 2'b11
  } state_e;

  logic             f1_q, f2_q;
  state_e           state_q;
  logic             freeze_q;
  logic [CNT_W-1:0] hold_q;
  logic [HP_W-1:0]  health1_q, health1_d, health2_q, health2_d;
  logic [CNT_W-1:0] cool1_q, cool1_d, cool2_q, cool2_d;
  logic             armed1_q, armed1_d, armed2_q, armed2_d;
  logic             hit1_q, hit2_q, kill1_q, kill2_q;

  logic tick_c, play_c, b1_on_c, b2_on_c, hit1_c, hit2_c, kill1_c, kill2_c, restart_ok_c;
  logic unused_c;

  // Only bit2 of the obstacle codes matters here; the side bits are for other consumers.
  assign unused_c = ^{disappear[1:0], disappear2[1:0]};

  assign tick_c       = f1_q & ~f2_q;
  assign play_c       = (state_q == PLAY);
  assign b1_on_c      = ~tank_bullet[2];
  assign b2_on_c      = ~tank_bullet2[2];
  assign hit2_c       = tick_c & play_c & b1_on_c & armed1_q & (cool2_q == '0);
  assign hit1_c       = tick_c & play_c & b2_on_c & armed2_q & (cool1_q == '0);
  assign kill1_c      = tick_c & play_c & (~disappear[2] | b1_on_c);
  assign kill2_c      = tick_c & play_c & (~disappear2[2] | b2_on_c);
  assign restart_ok_c = restart & ~play_c & (hold_q == HOLD_MAX);

  // Health, cooldown and per-bullet arming; an accepted restart overrides any tick.
  always_comb begin
    health1_d = health1_q;
    health2_d = health2_q;
    cool1_d   = cool1_q;
    cool2_d   = cool2_q;
    armed1_d  = armed1_q;
    armed2_d  = armed2_q;
    if (restart_ok_c) begin
      health1_d = HEALTH_INIT;
      health2_d = HEALTH_INIT;
      cool1_d   = '0;
      cool2_d   = '0;
      armed1_d  = 1'b1;
      armed2_d  = 1'b1;
    end else if (tick_c) begin
      if (cool1_q != '0) cool1_d = cool1_q - CNT_W'(1);
      if (cool2_q != '0) cool2_d = cool2_q - CNT_W'(1);
      if (hit1_c) begin
        health1_d = (health1_q == '0) ? '0 : health1_q - HP_W'(1);
        cool1_d   = COOL_LOAD;
        armed2_d  = 1'b0;
      end else if (tank_bullet2 == IDLE_CODE) begin
        armed2_d = 1'b1;
      end
      if (hit2_c) begin
        health2_d = (health2_q == '0) ? '0 : health2_q - HP_W'(1);
        cool2_d   = COOL_LOAD;
        armed1_d  = 1'b0;
      end else if (tank_bullet == IDLE_CODE) begin
        armed1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      f1_q      <= 1'b1;
      f2_q      <= 1'b1;
      health1_q <= HEALTH_INIT;
      health2_q <= HEALTH_INIT;
      cool1_q   <= '0;
      cool2_q   <= '0;
      armed1_q  <= 1'b1;
      armed2_q  <= 1'b1;
      hit1_q    <= 1'b0;
      hit2_q    <= 1'b0;
      kill1_q   <= 1'b0;
      kill2_q   <= 1'b0;
    end else begin
      f1_q      <= frame_clk;
      f2_q      <= f1_q;
      health1_q <= health1_d;
      health2_q <= health2_d;
      cool1_q   <= cool1_d;
      cool2_q   <= cool2_d;
      armed1_q  <= armed1_d;
      armed2_q  <= armed2_d;
      hit1_q    <= hit1_c;
      hit2_q    <= hit2_c;
      kill1_q   <= kill1_c;
      kill2_q   <= kill2_c;
    end
  end

  // Round FSM: decides from the health registered on the previous tick, then holds.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= PLAY;
      freeze_q <= 1'b0;
      hold_q   <= '0;
    end else if (restart_ok_c) begin
      state_q  <= PLAY;
      freeze_q <= 1'b0;
      hold_q   <= '0;
    end else if (tick_c) begin
      case (state_q)
        PLAY: begin
          if (health1_q == '0 && health2_q == '0) begin
            state_q  <= DRAW;
            freeze_q <= 1'b1;
            hold_q   <= '0;
          end else if (health2_q == '0) begin
            state_q  <= P1_WIN;
            freeze_q <= 1'b1;
            hold_q   <= '0;
          end else if (health1_q == '0) begin
            state_q  <= P2_WIN;
            freeze_q <= 1'b1;
            hold_q   <= '0;
          end
        end
        default: begin
          if (hold_q != HOLD_MAX) hold_q <= hold_q + CNT_W'(1);
        end
      endcase
    end
  end

`ifdef HIT_SIDE_LOG_EN
  logic [1:0] side1_q, side2_q;

  always_ff @(posedge Clk) begin
    if (Reset || restart_ok_c) begin
      side1_q <= 2'b00;
      side2_q <= 2'b00;
    end else begin
      if (hit1_c) side1_q <= tank_bullet2[1:0];
      if (hit2_c) side2_q <= tank_bullet[1:0];
    end
  end

  assign last_side1 = side1_q;
  assign last_side2 = side2_q;
`endif

  assign health1      = health1_q;
  assign health2      = health2_q;
  assign tank1_hit    = hit1_q;
  assign tank2_hit    = hit2_q;
  assign bullet_kill  = kill1_q;
  assign bullet2_kill = kill2_q;
  assign game_state   = state_q;
  assign freeze       = freeze_q;

endmodule

// File: tb/tb_tank_hit_tracker.sv
// Bench for tank_hit_tracker: per-cycle comparison against a behavioural round model,
// directed game scenarios with literal expectations, then randomized play.
module tb_tank_hit_tracker;

  localparam int unsigned HMAX = 3;
  localparam int unsigned COOL = 30;
  localparam int unsigned HOLD = 120;
  localparam logic [2:0]  IDLE = 3'b100;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] tank_bullet = IDLE, tank_bullet2 = IDLE, disappear = IDLE, disappear2 = IDLE;
  logic [2:0] health1, health2;
  logic       tank1_hit, tank2_hit, bullet_kill, bullet2_kill, freeze;
  logic [1:0] game_state;
`ifdef HIT_SIDE_LOG_EN
  logic [1:0] last_side1, last_side2;
`endif

  tank_hit_tracker #(
    .HEALTH_MAX(HMAX), .COOLDOWN_FRAMES(COOL), .OVER_HOLD_FRAMES(HOLD)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .tank_bullet(tank_bullet), .tank_bullet2(tank_bullet2),
    .disappear(disappear), .disappear2(disappear2), .restart(restart),
    .health1(health1), .health2(health2), .tank1_hit(tank1_hit), .tank2_hit(tank2_hit),
    .bullet_kill(bullet_kill), .bullet2_kill(bullet2_kill),
    .game_state(game_state), .freeze(freeze)
`ifdef HIT_SIDE_LOG_EN
    , .last_side1(last_side1), .last_side2(last_side2)
`endif
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  // Behavioural model: tank healths, cooldown timers, bullet arming and round outcome.
  int m_h1 = HMAX, m_h2 = HMAX, m_cd1 = 0, m_cd2 = 0, m_state = 0, m_hold = 0;
  int m_ls1 = 0, m_ls2 = 0;
  bit m_arm1 = 1, m_arm2 = 1, m_hit1 = 0, m_hit2 = 0, m_kill1 = 0, m_kill2 = 0;
  bit fr1 = 1, fr2 = 1;

  task automatic model_step();
    bit tick, play, on1, on2;
    int h1_was, h2_was;
    if (Reset) begin
      m_h1 = HMAX; m_h2 = HMAX; m_cd1 = 0; m_cd2 = 0; m_state = 0; m_hold = 0;
      m_arm1 = 1; m_arm2 = 1; m_hit1 = 0; m_hit2 = 0; m_kill1 = 0; m_kill2 = 0;
      m_ls1 = 0; m_ls2 = 0; fr1 = 1; fr2 = 1;
    end else begin
      tick = fr1 && !fr2;
      fr2 = fr1;
      fr1 = frame_clk;
      m_hit1 = 0; m_hit2 = 0; m_kill1 = 0; m_kill2 = 0;
      if (m_state != 0 && m_hold == HOLD && restart) begin
        m_h1 = HMAX; m_h2 = HMAX; m_cd1 = 0; m_cd2 = 0; m_state = 0; m_hold = 0;
        m_arm1 = 1; m_arm2 = 1; m_ls1 = 0; m_ls2 = 0;
      end else if (tick) begin
        play = (m_state == 0);
        on1 = (tank_bullet[2] == 1'b0);
        on2 = (tank_bullet2[2] == 1'b0);
        h1_was = m_h1;
        h2_was = m_h2;
        if (play) begin
          m_kill1 = (disappear[2] == 1'b0) || on1;
          m_kill2 = (disappear2[2] == 1'b0) || on2;
          m_hit2 = on1 && m_arm1 && m_cd2 == 0;
          m_hit1 = on2 && m_arm2 && m_cd1 == 0;
        end
        m_cd1 = m_hit1 ? COOL : (m_cd1 > 0 ? m_cd1 - 1 : 0);
        m_cd2 = m_hit2 ? COOL : (m_cd2 > 0 ? m_cd2 - 1 : 0);
        if (m_hit1) begin
          m_h1 = (m_h1 > 0) ? m_h1 - 1 : 0; m_arm2 = 0; m_ls1 = int'(tank_bullet2[1:0]);
        end else if (tank_bullet2 == IDLE) m_arm2 = 1;
        if (m_hit2) begin
          m_h2 = (m_h2 > 0) ? m_h2 - 1 : 0; m_arm1 = 0; m_ls2 = int'(tank_bullet[1:0]);
        end else if (tank_bullet == IDLE) m_arm1 = 1;
        if (play) begin
          if (h1_was == 0 && h2_was == 0) m_state = 3;
          else if (h2_was == 0) m_state = 1;
          else if (h1_was == 0) m_state = 2;
          if (m_state != 0) m_hold = 0;
        end else if (m_hold < HOLD) m_hold++;
      end
    end
  endtask

  task automatic compare_step();
    chk("health1", int'(health1), m_h1);
    chk("health2", int'(health2), m_h2);
    chk("tank1_hit", int'(tank1_hit), int'(m_hit1));
    chk("tank2_hit", int'(tank2_hit), int'(m_hit2));
    chk("bullet_kill", int'(bullet_kill), int'(m_kill1));
    chk("bullet2_kill", int'(bullet2_kill), int'(m_kill2));
    chk("game_state", int'(game_state), m_state);
    chk("freeze", int'(freeze), int'(m_state != 0));
`ifdef HIT_SIDE_LOG_EN
    chk("last_side1", int'(last_side1), m_ls1);
    chk("last_side2", int'(last_side2), m_ls2);
`endif
  endtask

  // Running pulse counts; read only on cycles where no pulse is present.
  int c_hit1 = 0, c_hit2 = 0, c_kill1 = 0, c_kill2 = 0;

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    c_hit1  += int'(tank1_hit);
    c_hit2  += int'(tank2_hit);
    c_kill1 += int'(bullet_kill);
    c_kill2 += int'(bullet2_kill);
    if (chk_en) compare_step();
  end

  // One frame = 4 Clk cycles, frame_clk high for the first two; codes held for the frame.
  task automatic frames(input logic [2:0] tb1, input logic [2:0] tb2,
                        input logic [2:0] d1, input logic [2:0] d2, input int n);
    repeat (n) begin
      @(negedge Clk);
      tank_bullet = tb1; tank_bullet2 = tb2; disappear = d1; disappear2 = d2;
      frame_clk = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic idle(input int n);
    frames(IDLE, IDLE, IDLE, IDLE, n);
  endtask

  task automatic pulse_restart();
    @(negedge Clk);
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
  endtask

  function automatic logic [2:0] rnd_code();
    if ($urandom_range(0, 2) == 0) return 3'($urandom_range(0, 3));
    return IDLE;
  endfunction

  int s_h2, s_k1, s_tot;

  initial begin
    repeat (2) @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("rst_health1", int'(health1), 3);
    chk("rst_health2", int'(health2), 3);
    chk("rst_state", int'(game_state), 0);
    chk("rst_freeze", int'(freeze), 0);

    s_tot = c_hit1 + c_hit2 + c_kill1 + c_kill2;
    idle(10);
    chk("idle_health1", int'(health1), 3);
    chk("idle_health2", int'(health2), 3);
    chk("idle_pulses", c_hit1 + c_hit2 + c_kill1 + c_kill2 - s_tot, 0);

    // Held overlap: one counted hit, a kill on every tick.
    s_h2 = c_hit2; s_k1 = c_kill1;
    frames(3'b010, IDLE, IDLE, IDLE, 5);
    chk("held_hits", c_hit2 - s_h2, 1);
    chk("held_kills", c_kill1 - s_k1, 5);
    chk("held_health2", int'(health2), 2);

    // New overlap 10 ticks after the hit lands inside the cooldown.
    idle(5);
    s_h2 = c_hit2; s_k1 = c_kill1;
    frames(3'b001, IDLE, IDLE, IDLE, 1);
    chk("cool_hits", c_hit2 - s_h2, 0);
    chk("cool_kills", c_kill1 - s_k1, 1);
    chk("cool_health2", int'(health2), 2);

    idle(31);
    frames(3'b000, IDLE, IDLE, IDLE, 1);
    chk("hit2_health2", int'(health2), 1);
    idle(31);
    frames(3'b011, IDLE, IDLE, IDLE, 1);
    chk("hit3_health2", int'(health2), 0);
    chk("hit3_state_lag", int'(game_state), 0);
    idle(1);
    chk("win_state", int'(game_state), 1);
    chk("win_freeze", int'(freeze), 1);
    chk("win_health1", int'(health1), 3);

    idle(50);
    pulse_restart();
    chk("early_restart_state", int'(game_state), 1);
    idle(75);
    pulse_restart();
    chk("restart_health1", int'(health1), 3);
    chk("restart_health2", int'(health2), 3);
    chk("restart_state", int'(game_state), 0);
    chk("restart_freeze", int'(freeze), 0);

    // Mutual hits down to a draw.
    frames(3'b001, 3'b011, IDLE, IDLE, 1);
    chk("mutual1_h1", int'(health1), 2);
    chk("mutual1_h2", int'(health2), 2);
    idle(31);
    frames(3'b000, 3'b010, IDLE, IDLE, 1);
    idle(31);
    frames(3'b011, 3'b000, IDLE, IDLE, 1);
    chk("draw_h1", int'(health1), 0);
    chk("draw_h2", int'(health2), 0);
    idle(1);
    chk("draw_state", int'(game_state), 3);

    idle(20);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midhold_reset_state", int'(game_state), 0);
    chk("midhold_reset_freeze", int'(freeze), 0);
    chk("midhold_reset_health1", int'(health1), 3);

    // Randomized play: frame strobe, codes, restart and rare resets all random per cycle.
    repeat (6000) begin
      @(negedge Clk);
      frame_clk    = 1'($urandom_range(0, 1));
      tank_bullet  = rnd_code();
      tank_bullet2 = rnd_code();
      disappear    = rnd_code();
      disappear2   = rnd_code();
      restart      = ($urandom_range(0, 19) == 0);
      Reset        = ($urandom_range(0, 2499) == 0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    restart = 1'b0;
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
